fb_write_arbiter: RTL

//  Shares one single-port synchronous frame-buffer SRAM between two requesters:
//  the SPI pixel stream (o_pixel_data/o_pixel_en_pls/o_vsync_pls from the SPI slave) and the LCD scan-out line fetcher.

---
 rtl/fb_write_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
// Generic synchronous FIFO with occupancy count; head entry is read straight from storage.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: caller qualifies i_push with o_full (push while full is legal only together with a pop).
module fb_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [W-1:0]     i_push_dat,
  input  logic             i_pop,
  output logic [W-1:0]     o_head_dat,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next storage, pointers and count; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_push) begin
      mem_d[wr_ptr_q] = i_push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (i_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; contents are discarded on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_head_dat = mem_q[rd_ptr_q];
  assign o_count    = count_q;
  assign o_full     = (count_q == CNT_W'(DEPTH));
  assign o_empty    = (count_q == '0);
endmodule

// Shares one single-port frame-buffer SRAM between the SPI pixel writer and the scan-out reader.
// Latency: grant -> SRAM strobe next cycle; read data MEM_RD_LAT cycles after o_mem_re.
// Backpressure: reads held by i_rd_req until o_rd_ack; pixels have none, a full FIFO drops and flags o_ovf_err.
module fb_write_arbiter #(
  parameter int WIDTH      = 480,
  parameter int HEIGHT     = 272,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_RD_RUN = 4,
  parameter int MEM_RD_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [15:0]       i_pixel_data,
  input  logic              i_pixel_en_pls,
  input  logic              i_vsync_pls,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic              o_rd_valid,
  output logic [15:0]       o_rd_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [15:0]       i_mem_rdata,
  output logic              o_ovf_err
);
  localparam int ENT_W = ADDR_W + 16;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int RUN_W = $clog2(MAX_RD_RUN + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [RUN_W-1:0]      run_cnt_q, run_cnt_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [15:0]           mem_wdata_q, mem_wdata_d;
  logic                  ovf_q, ovf_d;
  logic [MEM_RD_LAT-1:0] rd_vld_q, rd_vld_d;
  logic [15:0]           rd_data_q, rd_data_d;

  logic [ENT_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] pix_addr;
  logic              urgent;
  logic              grant_wr;
  logic              grant_rd;

  fb_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (push),
    .i_push_dat ({pix_addr, i_pixel_data}),
    .i_pop      (pop),
    .o_head_dat (fifo_head),
    .o_count    (fifo_count),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty)
  );

  // Arbitration: reads win unless the FIFO is nearly full, the read run is exhausted, or nobody reads.
  // o_rd_ack is combinational, so it is also held low while reset is asserted.
  always_comb begin
    urgent   = (fifo_count >= CNT_W'(FIFO_DEPTH - 2));
    grant_wr = !fifo_empty && (urgent || (run_cnt_q == RUN_W'(MAX_RD_RUN)) || !i_rd_req);
    grant_rd = i_rst_n && i_rd_req && !grant_wr;
  end

  // Pixel intake: address the pixel (vsync restarts at 0), push unless full without a pop, track overflow.
  always_comb begin
    pix_addr  = i_vsync_pls ? '0 : wr_addr_q;
    pop       = grant_wr;
    push      = i_pixel_en_pls && (!fifo_full || pop);
    wr_addr_d = wr_addr_q;
    if (push) begin
      wr_addr_d = (pix_addr == LAST_ADDR) ? '0 : pix_addr + ADDR_W'(1);
    end else if (i_vsync_pls) begin
      wr_addr_d = '0;
    end
    ovf_d = ovf_q | (i_pixel_en_pls && !push);
  end

  // Next SRAM command from the grant; idle fields keep their last value. Read run saturates.
  always_comb begin
    state_d     = ST_IDLE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    run_cnt_d   = run_cnt_q;
    if (grant_wr) begin
      state_d     = ST_WR;
      mem_addr_d  = fifo_head[ENT_W-1:16];
      mem_wdata_d = fifo_head[15:0];
    end else if (grant_rd) begin
      state_d    = ST_RD;
      mem_addr_d = i_rd_addr;
    end
    if (grant_wr || fifo_empty) begin
      run_cnt_d = '0;
    end else if (grant_rd && (run_cnt_q != RUN_W'(MAX_RD_RUN))) begin
      run_cnt_d = run_cnt_q + RUN_W'(1);
    end
  end

  // Read-return pipe: one valid bit per outstanding read, aligned to the SRAM read latency.
  always_comb begin
    rd_vld_d    = '0;
    rd_vld_d[0] = (state_q == ST_RD);
    for (int i = 1; i < MEM_RD_LAT; i++) rd_vld_d[i] = rd_vld_q[i-1];
    rd_data_d = rd_vld_q[MEM_RD_LAT-1] ? i_mem_rdata : rd_data_q;
  end

  // All arbiter state; reset drops any in-flight read returns.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      run_cnt_q   <= '0;
      wr_addr_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ovf_q       <= 1'b0;
      rd_vld_q    <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      wr_addr_q   <= wr_addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ovf_q       <= ovf_d;
      rd_vld_q    <= rd_vld_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign o_rd_ack    = grant_rd;
  assign o_mem_we    = (state_q == ST_WR);
  assign o_mem_re    = (state_q == ST_RD);
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_rd_valid  = rd_vld_q[MEM_RD_LAT-1];
  assign o_rd_data   = o_rd_valid ? i_mem_rdata : rd_data_q;
  assign o_ovf_err   = ovf_q;
endmodule
